mpu_bus_if: RTL and testbench

MPU_BUS_IF -- requirements
Module: mpu_bus_if

---
 rtl/mpu_bus_if_pkg.sv | 13 +
 rtl/mpu_bus_if_bus_timer.sv | 37 +++
 rtl/mpu_bus_if.sv | 111 +++++++++++
 tb/tb_mpu_bus_if.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_bus_if_pkg.sv
// Shared types and constants for the MPU-to-memory bus bridge.
package mpu_bus_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;
  localparam int         CNT_W            = 8;

endpackage

// File: rtl/mpu_bus_if_bus_timer.sv
// Wait-cycle counter for one memory request; flags when the abort limit is reached.
module bus_timer
  import mpu_bus_if_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == limit);

endmodule

// File: rtl/mpu_bus_if.sv
// Bridges single-cycle MPU accesses onto a req/ack memory bus with timeout abort.
module mpu_bus_if
  import mpu_bus_if_pkg::*;
#(
  parameter int         TIMEOUT  = 16,
  parameter logic [7:0] OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic        R_W,
  input  logic [7:0]  ABL,
  input  logic [7:0]  ABH,
  input  logic [7:0]  DB_OUT,
  input  logic        HALT,
  output logic [7:0]  DB_IN,
  output logic        RDY,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic [7:0]  MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        BUS_ERR
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        armed_q;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expired;
  logic        abort;

  assign timer_clear  = (state_q == REQ) && (MEM_ACK || timer_expired);
  assign timer_enable = (state_q == REQ) && !MEM_ACK;

  bus_timer u_bus_timer (
    .clk     (CLK),
    .rst_n   (RES_N),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .limit   (LIMIT),
    .expired (timer_expired)
  );

  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // armed_q holds off the first issue by one edge after reset release.
        if (!HALT && armed_q) begin
          addr_d  = {ABH, ABL};
          we_d    = ~R_W;
          wdata_d = DB_OUT;
          state_d = REQ;
        end
      end
      REQ: begin
        if (MEM_ACK) begin
          if (!we_q) rdata_d = MEM_RDATA;
          state_d = DONE;
        end else if (timer_expired) begin
          if (!we_q) rdata_d = OPEN_BUS;
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      armed_q <= 1'b1;
    end
  end

  assign MEM_REQ   = (state_q == REQ);
  assign RDY       = (state_q == DONE);
  assign BUS_ERR   = abort;
  assign MEM_ADDR  = addr_q;
  assign MEM_WE    = we_q;
  assign MEM_WDATA = wdata_q;
  assign DB_IN     = rdata_q;

endmodule

// File: tb/tb_mpu_bus_if.sv
// Directed bench for mpu_bus_if: read/write, waits, timeout, HALT and reset.
module tb_mpu_bus_if;
  logic        CLK = 1'b0;
  logic        RES_N;
  logic        R_W;
  logic [7:0]  ABL, ABH, DB_OUT;
  logic        HALT;
  logic [7:0]  DB_IN;
  logic        RDY, MEM_REQ, MEM_WE, BUS_ERR;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA, MEM_RDATA;
  logic        MEM_ACK;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mpu_bus_if #(.TIMEOUT(16), .OPEN_BUS(8'hFF)) dut (
    .CLK(CLK), .RES_N(RES_N), .R_W(R_W), .ABL(ABL), .ABH(ABH), .DB_OUT(DB_OUT),
    .HALT(HALT), .DB_IN(DB_IN), .RDY(RDY), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .MEM_ACK(MEM_ACK), .BUS_ERR(BUS_ERR)
  );

  // Start an access from IDLE: set the MPU inputs, drop HALT, step into REQ cycle 1.
  task automatic issue(input logic rw, input logic [15:0] addr, input logic [7:0] wd);
    R_W = rw; ABH = addr[15:8]; ABL = addr[7:0]; DB_OUT = wd; HALT = 1'b0;
    @(negedge CLK);
    HALT = 1'b1;
  endtask

  task automatic test_reset;
    RES_N = 1'b0; HALT = 1'b1; R_W = 1'b1; ABL = 8'h00; ABH = 8'h00; DB_OUT = 8'h00;
    MEM_ACK = 1'b0; MEM_RDATA = 8'h00;
    repeat (2) @(negedge CLK);
    checks++;
    if ({RDY, MEM_REQ, MEM_WE, BUS_ERR, MEM_ADDR, MEM_WDATA, DB_IN} !== 36'h0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b req=%b we=%b err=%b addr=%h wd=%h db=%h, want all 0",
               RDY, MEM_REQ, MEM_WE, BUS_ERR, MEM_ADDR, MEM_WDATA, DB_IN);
    end
    RES_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (MEM_REQ !== 1'b0) begin
      errors++; $display("FAIL reset_halt_idle: MEM_REQ=%b want 0", MEM_REQ);
    end
  endtask

  task automatic test_read_zero_wait;
    checks++;
    if (RDY !== 1'b0 || MEM_REQ !== 1'b0) begin
      errors++; $display("FAIL rd0_idle: rdy=%b req=%b want 0 0", RDY, MEM_REQ);
    end
    issue(1'b1, 16'h1234, 8'h00);
    checks++;
    if (MEM_REQ !== 1'b1 || MEM_ADDR !== 16'h1234 || MEM_WE !== 1'b0 || RDY !== 1'b0) begin
      errors++;
      $display("FAIL rd0_req: req=%b addr=%h we=%b rdy=%b want 1 1234 0 0", MEM_REQ, MEM_ADDR, MEM_WE, RDY);
    end
    MEM_ACK = 1'b1; MEM_RDATA = 8'hA5;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    checks++;
    if (RDY !== 1'b1 || MEM_REQ !== 1'b0 || DB_IN !== 8'hA5 || BUS_ERR !== 1'b0) begin
      errors++;
      $display("FAIL rd0_done: rdy=%b req=%b db=%h err=%b want 1 0 a5 0", RDY, MEM_REQ, DB_IN, BUS_ERR);
    end
    @(negedge CLK);
    checks++;
    if (RDY !== 1'b0 || MEM_REQ !== 1'b0) begin
      errors++; $display("FAIL rd0_rdy_width: rdy=%b req=%b want 0 0", RDY, MEM_REQ);
    end
  endtask

  task automatic test_write_waits;
    int bad = 0;
    issue(1'b0, 16'h0080, 8'h5A);
    for (int i = 1; i <= 4; i++) begin
      if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1 || MEM_WDATA !== 8'h5A ||
          MEM_ADDR !== 16'h0080 || RDY !== 1'b0) begin
        bad++;
        $display("FAIL wr_req_cycle%0d: req=%b we=%b wd=%h addr=%h rdy=%b want 1 1 5a 0080 0",
                 i, MEM_REQ, MEM_WE, MEM_WDATA, MEM_ADDR, RDY);
      end
      ABL = 8'hFF; DB_OUT = 8'h00; R_W = 1'b1;
      if (i == 4) begin MEM_ACK = 1'b1; MEM_RDATA = 8'h77; end
      @(negedge CLK);
    end
    MEM_ACK = 1'b0;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (RDY !== 1'b1 || DB_IN !== 8'hA5 || MEM_REQ !== 1'b0) begin
      errors++; $display("FAIL wr_done: rdy=%b db=%h req=%b want 1 a5 0", RDY, DB_IN, MEM_REQ);
    end
    @(negedge CLK);
    checks++;
    if (RDY !== 1'b0 || DB_IN !== 8'hA5) begin
      errors++; $display("FAIL wr_after: rdy=%b db=%h want 0 a5", RDY, DB_IN);
    end
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    int err_cycles = 0;
    int err_at = 0;
    issue(1'b1, 16'h4000, 8'h00);
    for (int i = 1; i <= 20 && MEM_REQ === 1'b1; i++) begin
      req_cycles++;
      if (BUS_ERR === 1'b1) begin err_cycles++; err_at = i; end
      @(negedge CLK);
    end
    checks++;
    if (req_cycles != 16) begin
      errors++; $display("FAIL to_req_len: got %0d cycles want 16", req_cycles);
    end
    checks++;
    if (err_cycles != 1 || err_at != 16) begin
      errors++; $display("FAIL to_buserr: pulses=%0d at=%0d want 1 at 16", err_cycles, err_at);
    end
    checks++;
    if (RDY !== 1'b1 || DB_IN !== 8'hFF || BUS_ERR !== 1'b0) begin
      errors++; $display("FAIL to_done: rdy=%b db=%h err=%b want 1 ff 0", RDY, DB_IN, BUS_ERR);
    end
    @(negedge CLK);
  endtask

  task automatic test_coincidence;
    issue(1'b1, 16'h4001, 8'h00);
    repeat (15) @(negedge CLK);
    MEM_ACK = 1'b1; MEM_RDATA = 8'h3C;
    #1;
    checks++;
    if (MEM_REQ !== 1'b1 || BUS_ERR !== 1'b0) begin
      errors++; $display("FAIL co_req16: req=%b err=%b want 1 0", MEM_REQ, BUS_ERR);
    end
    @(negedge CLK);
    MEM_ACK = 1'b0;
    checks++;
    if (RDY !== 1'b1 || DB_IN !== 8'h3C || BUS_ERR !== 1'b0) begin
      errors++; $display("FAIL co_done: rdy=%b db=%h err=%b want 1 3c 0", RDY, DB_IN, BUS_ERR);
    end
    @(negedge CLK);
  endtask

  task automatic test_halt;
    int leaked = 0;
    R_W = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ABH = 8'h11; ABL = 8'(i);
      @(negedge CLK);
      if (MEM_REQ !== 1'b0) leaked++;
    end
    checks++;
    if (leaked != 0) begin
      errors++; $display("FAIL halt_idle: MEM_REQ high in %0d cycles want 0", leaked);
    end
    issue(1'b1, 16'hBEEF, 8'h00);
    checks++;
    if (MEM_REQ !== 1'b1 || MEM_ADDR !== 16'hBEEF) begin
      errors++; $display("FAIL halt_release: req=%b addr=%h want 1 beef", MEM_REQ, MEM_ADDR);
    end
    repeat (2) @(negedge CLK);
    MEM_ACK = 1'b1; MEM_RDATA = 8'hC3;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    checks++;
    if (RDY !== 1'b1 || DB_IN !== 8'hC3) begin
      errors++; $display("FAIL halt_midreq: rdy=%b db=%h want 1 c3", RDY, DB_IN);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 16'h2222, 8'h99);
    @(negedge CLK);
    #1 RES_N = 1'b0;
    #1;
    checks++;
    if (MEM_REQ !== 1'b0 || RDY !== 1'b0 || DB_IN !== 8'h00 || MEM_WE !== 1'b0 ||
        MEM_ADDR !== 16'h0000 || MEM_WDATA !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: req=%b rdy=%b db=%h we=%b addr=%h wd=%h want 0 0 00 0 0000 00",
               MEM_REQ, RDY, DB_IN, MEM_WE, MEM_ADDR, MEM_WDATA);
    end
    @(negedge CLK);
    R_W = 1'b1; ABH = 8'h56; ABL = 8'h78; HALT = 1'b0;
    RES_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (MEM_REQ !== 1'b0) begin
      errors++; $display("FAIL rst_first_edge: MEM_REQ=%b want 0", MEM_REQ);
    end
    @(negedge CLK);
    HALT = 1'b1;
    checks++;
    if (MEM_REQ !== 1'b1 || MEM_ADDR !== 16'h5678 || MEM_WE !== 1'b0) begin
      errors++; $display("FAIL rst_fresh_req: req=%b addr=%h we=%b want 1 5678 0", MEM_REQ, MEM_ADDR, MEM_WE);
    end
    MEM_ACK = 1'b1; MEM_RDATA = 8'h5E;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    checks++;
    if (RDY !== 1'b1 || DB_IN !== 8'h5E) begin
      errors++; $display("FAIL rst_fresh_done: rdy=%b db=%h want 1 5e", RDY, DB_IN);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_timeout();
    test_coincidence();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
